wots_chain_ctrl: RTL and testbench
==================================

WOTS_CHAIN_CTRL -- requirements
Module: wots_chain_ctrl

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port start  in  1  one-cycle request; accepted only in IDLE.
REQ-004 SHALL have port x_in  in  256  chain input value.
REQ-005 SHALL have port pub_seed  in  256  public seed; sampled at accepted start.
REQ-006 SHALL have port adrs  in  256  XMSS ADRS, word0 at [255:224]; hash address [63:32], keyAndMask [31:0]; sampled at accepted start.
REQ-007 SHALL have port start_idx  in  4  first chain position s, 0..15.
REQ-008 SHALL have port steps  in  4  requested iterations.
REQ-009 SHALL have port x_out  out  256  registered result; holds until next done.
REQ-010 SHALL have ports done  out  1  (one-cycle result pulse) and busy  out  1  (high from cycle after accepted start until done).
REQ-011 SHALL have hash-side ports h_start out 1, h_data_in out 1024, h_message_length out 1, h_store_intermediate out 1, h_continue_intermediate out 1, h_second_block_data_available out 1, h_data_out in 256, h_done in 1, h_busy in 1.

Function
REQ-012 SHALL perform n = min(steps, 15 - start_idx) chain iterations; iteration i uses hash address start_idx + i.
REQ-013 Per iteration SHALL issue three hashes in order: KEY = PRF(seed, ADRS with keyAndMask = 0), MASK = PRF(seed, ADRS with keyAndMask = 1), then X = F = H(toByte(0,32) || KEY || (X xor MASK)).
REQ-014 PRF message SHALL be toByte(3,32) || seed || ADRS; all messages 768 bits, placed in h_data_in[1023:256], h_data_in[255:0] = 0, h_message_length = 0.
REQ-015 h_second_block_data_available SHALL be tied high; h_data_in and flags SHALL be valid in the h_start cycle and held stable until h_done.
REQ-016 h_start SHALL be one cycle high, issued only when h_busy is low, never within the cycle h_done is seen.
REQ-017 FSM states: IDLE, PRE, KEY, MASK, F, FIN; IDLE->PRE/KEY on start (n > 0), IDLE->FIN on start (n = 0); KEY->MASK->F on h_done; F->KEY on h_done if iterations remain, else F->FIN; FIN->IDLE after one cycle asserting done.
REQ-018 n = 0: x_out = x_in, done exactly two cycles after start, no h_start.
REQ-019 start while busy SHALL be ignored with no state change; h_done outside KEY/MASK/F/PRE SHALL be ignored.
REQ-020 Hash address increment SHALL not wrap beyond 15 (guaranteed by REQ-012 clamp).
REQ-021 Reset values: x_out = 0, done = 0, busy = 0, h_start = 0, all h_* flags 0, h_data_in = 0, state IDLE.

Reset
REQ-022 reset mid-operation SHALL return to IDLE in the next cycle, drop busy, suppress done, and invalidate the seed cache; a pending hash result is discarded.

Configuration
REQ-023 With WOTS_CHAIN_PRF_PRECOMP_EN defined: seed cache (256-bit seed + valid bit); if at start the cache is invalid or differs from pub_seed, state PRE issues one hash with h_store_intermediate = 1 over toByte(3,32) || seed, then updates the cache; each PRF then uses h_continue_intermediate = 1 with ADRS in h_data_in[511:256].
REQ-024 Without WOTS_CHAIN_PRF_PRECOMP_EN: no PRE state, no cache; every PRF is a full 768-bit hash with store/continue flags held 0.

Structure
REQ-025 Shared package wots_pkg SHALL hold W = 16, PRF_PAD = toByte(3,32), F_PAD = toByte(0,32), ADRS field bit offsets, state encoding.
REQ-026 Sub-module wots_msg_fmt (combinational) SHALL build h_data_in and flags from state, seed, ADRS, key, mask and X.

Verification
REQ-027 start_idx = 3, steps = 0 -> done after 2 cycles, x_out = x_in, zero h_start pulses.
REQ-028 start_idx = 0, steps = 1, known seed/ADRS/x_in -> x_out matches software F(KEY, x_in xor MASK); 3 h_start pulses (4 with macro, fresh cache).
REQ-029 start_idx = 0, steps = 15 -> x_out equals software chain result; hash addresses 0..14 seen in order.
REQ-030 start_idx = 14, steps = 5 -> exactly one iteration, hash address 14.
REQ-031 start pulsed during busy -> ignored; single done with first job's result.
REQ-032 With macro: two jobs same seed -> store hash only once; third job new seed -> one new store; reset mid-job -> busy low next cycle, next job re-stores.

Source files
------------

// File: rtl/wots_pkg.sv
// Shared constants, ADRS field layout and FSM encoding for the WOTS+ chain controller.
package wots_pkg;

    localparam int W     = 16;
    localparam int N_W   = 256;
    localparam int MSG_W = 1024;

    localparam logic [N_W-1:0] PRF_PAD = 256'd3;
    localparam logic [N_W-1:0] F_PAD   = 256'd0;

    // ADRS word0 sits at [255:224]; only hash address and keyAndMask are rewritten here
    localparam int ADRS_HASH_LSB = 32;
    localparam int ADRS_HASH_W   = 32;
    localparam int ADRS_KM_LSB   = 0;
    localparam int ADRS_KM_W     = 32;

    localparam logic [31:0] KM_KEY  = 32'd0;
    localparam logic [31:0] KM_MASK = 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_KEY  = 3'd2,
        ST_MASK = 3'd3,
        ST_F    = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    function automatic logic [N_W-1:0] adrs_set(input logic [N_W-1:0] base,
                                                input logic [3:0]     hash_addr,
                                                input logic [31:0]    key_and_mask);
        logic [N_W-1:0] a;
        a = base;
        a[ADRS_HASH_LSB +: ADRS_HASH_W] = {28'd0, hash_addr};
        a[ADRS_KM_LSB +: ADRS_KM_W]     = key_and_mask;
        return a;
    endfunction

    // Iterations are clamped so the chain never walks past position W-1
    function automatic logic [3:0] chain_len(input logic [3:0] start_idx,
                                             input logic [3:0] steps);
        logic [3:0] room;
        room = 4'(W - 1) - start_idx;
        return (steps < room) ? steps : room;
    endfunction

endpackage

// File: rtl/wots_msg_fmt.sv
// Combinational hash message builder for the WOTS+ chain FSM.
// WOTS_CHAIN_PRF_PRECOMP_EN selects the cached-seed (store/continue) PRF layout.
module wots_msg_fmt
    import wots_pkg::*;
(
    input  state_t           state,
    input  logic [N_W-1:0]   seed,
    input  logic [N_W-1:0]   adrs,
    input  logic [3:0]       hash_addr,
    input  logic [N_W-1:0]   key,
    input  logic [N_W-1:0]   mask,
    input  logic [N_W-1:0]   x,
    output logic [MSG_W-1:0] data,
    output logic             message_length,
    output logic             store_intermediate,
    output logic             continue_intermediate
);

    logic [N_W-1:0] adrs_key;
    logic [N_W-1:0] adrs_mask;

    assign adrs_key  = adrs_set(adrs, hash_addr, KM_KEY);
    assign adrs_mask = adrs_set(adrs, hash_addr, KM_MASK);

    always_comb begin
        data                  = '0;
        message_length        = 1'b0;
        store_intermediate    = 1'b0;
        continue_intermediate = 1'b0;
        case (state)
`ifdef WOTS_CHAIN_PRF_PRECOMP_EN
            ST_PRE: begin
                data[1023:512]     = {PRF_PAD, seed};
                store_intermediate = 1'b1;
            end
            ST_KEY: begin
                data[511:256]         = adrs_key;
                continue_intermediate = 1'b1;
            end
            ST_MASK: begin
                data[511:256]         = adrs_mask;
                continue_intermediate = 1'b1;
            end
`else
            ST_KEY:  data[1023:256] = {PRF_PAD, seed, adrs_key};
            ST_MASK: data[1023:256] = {PRF_PAD, seed, adrs_mask};
`endif
            ST_F:    data[1023:256] = {F_PAD, key, x ^ mask};
            default: ;
        endcase
    end

endmodule

// File: rtl/wots_chain_ctrl.sv
// WOTS+ chain controller: drives an external SHA-256 core through KEY/MASK/F per step.
// Define WOTS_CHAIN_PRF_PRECOMP_EN to cache the seed block and skip it in every PRF.
module wots_chain_ctrl
    import wots_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   x_in,
    input  logic [N_W-1:0]   pub_seed,
    input  logic [N_W-1:0]   adrs,
    input  logic [3:0]       start_idx,
    input  logic [3:0]       steps,
    output logic [N_W-1:0]   x_out,
    output logic             done,
    output logic             busy,
    output logic             h_start,
    output logic [MSG_W-1:0] h_data_in,
    output logic             h_message_length,
    output logic             h_store_intermediate,
    output logic             h_continue_intermediate,
    output logic             h_second_block_data_available,
    input  logic [N_W-1:0]   h_data_out,
    input  logic             h_done,
    input  logic             h_busy
);

    state_t         state;
    state_t         state_next;
    logic           issued;
    logic           rsp;
    logic           hash_state;
    logic           need_pre;
    logic [3:0]     n_req;
    logic [3:0]     hash_addr;
    logic [3:0]     iter_left;
    logic [N_W-1:0] seed_q;
    logic [N_W-1:0] adrs_q;
    logic [N_W-1:0] x_q;
    logic [N_W-1:0] key_q;
    logic [N_W-1:0] mask_q;

    assign n_req      = chain_len(start_idx, steps);
    assign hash_state = state inside {ST_PRE, ST_KEY, ST_MASK, ST_F};
    // A result only counts if this state issued the request; stale completions are dropped
    assign rsp        = hash_state && issued && h_done;

`ifdef WOTS_CHAIN_PRF_PRECOMP_EN
    logic [N_W-1:0] seed_cache;
    logic           cache_vld;

    assign need_pre = !cache_vld || (seed_cache != pub_seed);

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld <= 1'b0;
        end else if (state == ST_PRE && rsp) begin
            cache_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_PRE && rsp) begin
            seed_cache <= seed_q;
        end
    end
`else
    assign need_pre = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (n_req == 4'd0) begin
                        state_next = ST_FIN;
                    end else if (need_pre) begin
                        state_next = ST_PRE;
                    end else begin
                        state_next = ST_KEY;
                    end
                end
            end
            ST_PRE:  if (rsp) state_next = ST_KEY;
            ST_KEY:  if (rsp) state_next = ST_MASK;
            ST_MASK: if (rsp) state_next = ST_F;
            ST_F:    if (rsp) state_next = (iter_left == 4'd1) ? ST_FIN : ST_KEY;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        h_start = !reset && hash_state && !issued && !h_busy && !h_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued <= 1'b0;
            done   <= 1'b0;
            x_out  <= '0;
        end else begin
            issued <= (state_next == state) && (issued || h_start);
            done   <= (state == ST_FIN);
            if (state == ST_FIN) begin
                x_out <= x_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            seed_q    <= pub_seed;
            adrs_q    <= adrs;
            x_q       <= x_in;
            hash_addr <= start_idx;
            iter_left <= n_req;
        end
        if (rsp) begin
            case (state)
                ST_KEY:  key_q  <= h_data_out;
                ST_MASK: mask_q <= h_data_out;
                ST_F: begin
                    x_q       <= h_data_out;
                    hash_addr <= hash_addr + 4'd1;
                    iter_left <= iter_left - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign h_second_block_data_available = 1'b1;

    wots_msg_fmt u_msg_fmt (
        .state                 (state),
        .seed                  (seed_q),
        .adrs                  (adrs_q),
        .hash_addr             (hash_addr),
        .key                   (key_q),
        .mask                  (mask_q),
        .x                     (x_q),
        .data                  (h_data_in),
        .message_length        (h_message_length),
        .store_intermediate    (h_store_intermediate),
        .continue_intermediate (h_continue_intermediate)
    );

endmodule

// File: tb/tb_wots_chain_ctrl.sv
// Scoreboard bench for wots_chain_ctrl with a toy hash-core responder.
// Honours WOTS_CHAIN_PRF_PRECOMP_EN for expected pulse/store counts.
module tb_wots_chain_ctrl;

`ifdef WOTS_CHAIN_PRF_PRECOMP_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [255:0]  x_in;
    logic [255:0]  pub_seed;
    logic [255:0]  adrs;
    logic [3:0]    start_idx;
    logic [3:0]    steps;
    logic [255:0]  x_out;
    logic          done;
    logic          busy;
    logic          h_start;
    logic [1023:0] h_data_in;
    logic          h_message_length;
    logic          h_store_intermediate;
    logic          h_continue_intermediate;
    logic          h_second_block_data_available;
    logic [255:0]  h_data_out = '0;
    logic          h_done = 1'b0;
    logic          h_busy = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wots_chain_ctrl dut (
        .clk                           (clk),
        .reset                         (reset),
        .start                         (start),
        .x_in                          (x_in),
        .pub_seed                      (pub_seed),
        .adrs                          (adrs),
        .start_idx                     (start_idx),
        .steps                         (steps),
        .x_out                         (x_out),
        .done                          (done),
        .busy                          (busy),
        .h_start                       (h_start),
        .h_data_in                     (h_data_in),
        .h_message_length              (h_message_length),
        .h_store_intermediate          (h_store_intermediate),
        .h_continue_intermediate       (h_continue_intermediate),
        .h_second_block_data_available (h_second_block_data_available),
        .h_data_out                    (h_data_out),
        .h_done                        (h_done),
        .h_busy                        (h_busy)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in for SHA-256: order- and position-sensitive, cheap to evaluate
    function automatic logic [255:0] toy_hash(input logic [1023:0] d);
        logic [255:0] acc;
        acc = {8{32'h9e3779b9}};
        for (int k = 3; k >= 0; k--) begin
            acc = {acc[242:0], acc[255:243]} + (d[k*256 +: 256] ^ {8{32'h6a09e667}} ^ 256'(k + 1));
        end
        return acc ^ {acc[127:0], acc[255:128]};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] set_adrs(input logic [255:0] a, input int ha, input int km);
        a[63:32] = 32'(ha);
        a[31:0]  = 32'(km);
        return a;
    endfunction

    function automatic logic [255:0] sw_prf(input logic [255:0] seed, input logic [255:0] a);
`ifdef WOTS_CHAIN_PRF_PRECOMP_EN
        logic [255:0] m;
        m = toy_hash({256'd3, seed, 512'd0});
        return toy_hash({m, 256'd0, a, 256'd0});
`else
        return toy_hash({256'd3, seed, a, 256'd0});
`endif
    endfunction

    function automatic logic [255:0] sw_chain(input logic [255:0] x, input logic [255:0] seed,
                                              input logic [255:0] base, input int s, input int st);
        int n;
        logic [255:0] key;
        logic [255:0] mask;
        n = (st < 15 - s) ? st : 15 - s;
        for (int i = 0; i < n; i++) begin
            key  = sw_prf(seed, set_adrs(base, s + i, 0));
            mask = sw_prf(seed, set_adrs(base, s + i, 1));
            x    = toy_hash({256'd0, key, x ^ mask, 256'd0});
        end
        return x;
    endfunction

    // Hash-core responder
    logic [1023:0] cap_data;
    logic          cap_store;
    logic          cap_cont;
    logic          pending = 1'b0;
    logic          stale = 1'b0;
    logic [255:0]  mid = '0;
    logic [255:0]  res;
    int            lat_cnt = 0;
    int            n_hstart = 0;
    int            n_store = 0;
    int            proto_err = 0;
    int            addr_log[$];
    logic          inj_done = 1'b0;

    always @(posedge clk) begin
        h_done <= 1'b0;
        if (pending) begin
            if (!stale && !reset && h_data_in !== cap_data) proto_err++;
            if (reset) stale <= 1'b1;
            if (lat_cnt == 0) begin
                res = toy_hash(cap_cont ? (cap_data ^ {mid, 768'd0}) : cap_data);
                if (cap_store) mid <= res;
                h_data_out <= res;
                h_done     <= 1'b1;
                h_busy     <= 1'b0;
                pending    <= 1'b0;
                stale      <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end else if (inj_done) begin
            h_done     <= 1'b1;
            h_data_out <= '1;
        end
        if (h_start) begin
            n_hstart++;
            if (h_busy || h_done) proto_err++;
            if (h_store_intermediate) n_store++;
            if (h_data_in[287:256] == 32'd0 &&
                (h_continue_intermediate || (h_data_in[1023:768] == 256'd3 && !h_store_intermediate)))
                addr_log.push_back(int'(h_data_in[319:288]));
            pending   <= 1'b1;
            stale     <= reset;
            h_busy    <= 1'b1;
            lat_cnt   <= int'($urandom_range(3));
            cap_data  <= h_data_in;
            cap_store <= h_store_intermediate;
            cap_cont  <= h_continue_intermediate;
        end
    end

    // Scoreboard: every done pops one expected chain result
    logic [255:0] exp_q[$];
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) check("extra_done", 256'(done), 256'd0);
            else check("x_out", x_out, exp_q.pop_front());
        end
    end

    int           hs0;
    int           st0;
    logic [255:0] last_x;

    task automatic launch(input int s, input int st, input logic [255:0] x,
                          input logic [255:0] sd, input logic [255:0] a);
        @(negedge clk);
        start_idx = 4'(s);
        steps     = 4'(st);
        x_in      = x;
        pub_seed  = sd;
        adrs      = a;
        start     = 1'b1;
        last_x    = sw_chain(x, sd, a, s, st);
        exp_q.push_back(last_x);
        hs0 = n_hstart;
        st0 = n_store;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 256'(busy), 256'd1);
    endtask

    task automatic wait_done(input int exp_lat, input int exp_hs, input int exp_store);
        int lat;
        lat = 1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", 256'(done), 256'd1);
        if (exp_lat > 0) check("done_latency", 256'(lat), 256'(exp_lat));
        check("h_start_count", 256'(n_hstart - hs0), 256'(exp_hs));
        check("store_count", 256'(n_store - st0), 256'(exp_store));
        @(negedge clk);
        check("done_one_cycle", 256'(done), 256'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] seed_a;
        logic [255:0] seed_b;
        logic [255:0] base;
        int s;
        int st;
        int n;

        reset = 1'b1; start = 1'b0; x_in = '0; pub_seed = '0; adrs = '0;
        start_idx = '0; steps = '0;
        seed_a = rnd256();
        seed_b = rnd256();
        base   = rnd256();
        repeat (3) @(negedge clk);
        check("rst_x_out", x_out, 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_h_start", 256'(h_start), 256'd0);
        check("rst_h_data_hi", h_data_in[1023:768] | h_data_in[767:512], 256'd0);
        check("rst_h_data_lo", h_data_in[511:256] | h_data_in[255:0], 256'd0);
        check("rst_h_flags", 256'({h_message_length, h_store_intermediate, h_continue_intermediate}), 256'd0);
        reset = 1'b0;
        @(negedge clk);

        // zero-length chain: pass-through after two cycles, no hashing
        launch(3, 0, rnd256(), seed_a, base);
        wait_done(2, 0, 0);

        // single iteration from position 0
        addr_log.delete();
        launch(0, 1, rnd256(), seed_a, base);
        wait_done(-1, 3 + PRE, PRE);
        check("single_addr_cnt", 256'(addr_log.size()), 256'd1);

        // full chain, hash addresses 0..14 in order
        addr_log.delete();
        launch(0, 15, rnd256(), seed_a, base);
        wait_done(-1, 45, 0);
        check("full_addr_cnt", 256'(addr_log.size()), 256'd15);
        for (int i = 0; i < 15 && i < addr_log.size(); i++)
            check("full_addr_seq", 256'(addr_log[i]), 256'(i));

        // clamp at the top of the chain
        addr_log.delete();
        launch(14, 5, rnd256(), seed_a, base);
        wait_done(-1, 3, 0);
        check("clamp_addr_cnt", 256'(addr_log.size()), 256'd1);
        if (addr_log.size() > 0) check("clamp_addr", 256'(addr_log[0]), 256'd14);

        // new seed forces one fresh seed block
        launch(5, 4, rnd256(), seed_b, base);
        wait_done(-1, 12 + PRE, PRE);

        for (int j = 0; j < 4; j++) begin
            s  = int'($urandom_range(15));
            st = int'($urandom_range(15));
            n  = (st < 15 - s) ? st : 15 - s;
            launch(s, st, rnd256(), seed_b, rnd256());
            wait_done(-1, 3 * n, 0);
        end

        // start while busy must be ignored
        launch(2, 3, rnd256(), seed_b, base);
        @(negedge clk);
        start_idx = 4'd0; steps = 4'd15; x_in = rnd256(); pub_seed = seed_a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(-1, 9, 0);
        repeat (6) @(negedge clk);

        // spurious h_done in IDLE must not disturb anything
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hdone_busy", 256'(busy), 256'd0);
        check("idle_hdone_x_out", x_out, last_x);

        // reset mid-job: busy drops next cycle, no done, cache invalidated
        launch(0, 6, rnd256(), seed_b, base);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_x_out", x_out, 256'd0);
        exp_q.delete();
        repeat (8) @(negedge clk);
        launch(1, 2, rnd256(), seed_b, base);
        wait_done(-1, 6 + PRE, PRE);

        repeat (4) @(negedge clk);
        check("protocol_errors", 256'(proto_err), 256'd0);
        check("scoreboard_empty", 256'(exp_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
